// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: round-robin sharing of one active-low RGB LED between N_REQ requesters.
// An owner holds the LED for HOLD_CYCLES, then the LED is blanked for GAP_CYCLES before re-arbitration.
module rgb_led_arbiter #(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 2000000,
    parameter int GAP_CYCLES  = 200000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] color,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic               RGB_R,
    output logic               RGB_G,
    output logic               RGB_B
);
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int LW      = $clog2(N_REQ);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    last_q, last_d;
    logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic             busy_q, busy_d;
    logic [2:0]       rgb_q, rgb_d;
    logic             found;
    logic [LW-1:0]    win;
    logic [2:0]       col_w;

    // Search last_q+1, last_q+2, ... so the previous owner is considered last.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        col_w = 3'b000;
        for (int k = 1; k <= N_REQ; k++)
            for (int i = 0; i < N_REQ; i++)
                if (!found && req[i] && i == (int'(last_q) + k) % N_REQ) begin
                    found = 1'b1;
                    win   = LW'(i);
                end
        for (int i = 0; i < N_REQ; i++)
            if (int'(win) == i) col_w = color[3*i +: 3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= LW'(N_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            rgb_q   <= 3'b111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rgb_q   <= rgb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = HOLD;
                cnt_d   = '0;
                last_d  = win;
            end
            HOLD: if (cnt_q == HOLD_LAST) begin
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
            GAP: if (cnt_q == GAP_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
            default: state_d = IDLE;
        endcase
    end

    // Colour is captured only on the IDLE->HOLD edge; rgb_q itself is the latch.
    always_comb begin
        grant_d = '0;
        for (int i = 0; i < N_REQ; i++)
            grant_d[i] = (state_d == HOLD) && ((state_q == IDLE) ? int'(win) == i : grant_q[i]);
        done_d = (state_q == HOLD && state_d != HOLD) ? grant_q : '0;
        busy_d = state_d != IDLE;
        rgb_d  = (state_d != HOLD) ? 3'b111 : (state_q == IDLE) ? ~col_w : rgb_q;
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign RGB_R = rgb_q[2];
    assign RGB_G = rgb_q[1];
    assign RGB_B = rgb_q[0];
endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: directed vector table plus hand sequences for async reset and zero-gap operation.
module tb_rgb_led_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [8:0] color = 9'b0;
    logic [2:0] grant, done, grant0, done0;
    logic       busy, busy0, r, g, b, r0, g0, b0;
    int         errors = 0;
    int         checks = 0;

    localparam logic [8:0] CD = 9'b011_110_100;
    localparam logic [8:0] CL = 9'b011_110_001;

    typedef struct {
        logic       rst_n;
        logic [2:0] req;
        logic [8:0] color;
        logic [2:0] g;
        logic [2:0] d;
        logic       b;
        logic [2:0] rgb;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    rgb_led_arbiter #(.N_REQ(3), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .color(color), .grant(grant), .done(done),
        .busy(busy), .RGB_R(r), .RGB_G(g), .RGB_B(b));

    rgb_led_arbiter #(.N_REQ(3), .HOLD_CYCLES(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .color(color), .grant(grant0), .done(done0),
        .busy(busy0), .RGB_R(r0), .RGB_G(g0), .RGB_B(b0));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic rs, input logic [2:0] rq, input logic [8:0] c,
                       input logic [2:0] eg, input logic [2:0] ed, input logic eb, input logic [2:0] er);
        for (int i = 0; i < n; i++) vecs.push_back('{rs, rq, c, eg, ed, eb, er});
    endtask

    initial begin
        // reset with all requesting, then round-robin 0,1,2,0
        add(2, 0, 3'b111, CD, 3'b000, 3'b000, 0, 3'b111);
        add(4, 1, 3'b111, CD, 3'b001, 3'b000, 1, 3'b011);
        add(1, 1, 3'b111, CD, 3'b000, 3'b001, 1, 3'b111);
        add(1, 1, 3'b111, CD, 3'b000, 3'b000, 1, 3'b111);
        add(1, 1, 3'b111, CD, 3'b000, 3'b000, 0, 3'b111);
        add(4, 1, 3'b111, CD, 3'b010, 3'b000, 1, 3'b001);
        add(1, 1, 3'b111, CD, 3'b000, 3'b010, 1, 3'b111);
        add(1, 1, 3'b111, CD, 3'b000, 3'b000, 1, 3'b111);
        add(1, 1, 3'b111, CD, 3'b000, 3'b000, 0, 3'b111);
        add(4, 1, 3'b111, CD, 3'b100, 3'b000, 1, 3'b100);
        add(1, 1, 3'b111, CD, 3'b000, 3'b100, 1, 3'b111);
        add(1, 1, 3'b111, CD, 3'b000, 3'b000, 1, 3'b111);
        add(1, 1, 3'b111, CD, 3'b000, 3'b000, 0, 3'b111);
        // colour change mid-hold must not reach the pins
        add(1, 1, 3'b111, CD, 3'b001, 3'b000, 1, 3'b011);
        add(3, 1, 3'b111, CL, 3'b001, 3'b000, 1, 3'b011);
        add(1, 1, 3'b000, CL, 3'b000, 3'b001, 1, 3'b111);
        add(1, 1, 3'b000, CD, 3'b000, 3'b000, 1, 3'b111);
        add(2, 1, 3'b000, CD, 3'b000, 3'b000, 0, 3'b111);
        // single grant to requester 1, request dropped during hold
        add(1, 1, 3'b010, CD, 3'b010, 3'b000, 1, 3'b001);
        add(3, 1, 3'b000, CD, 3'b010, 3'b000, 1, 3'b001);
        add(1, 1, 3'b000, CD, 3'b000, 3'b010, 1, 3'b111);
        add(1, 1, 3'b000, CD, 3'b000, 3'b000, 1, 3'b111);
        add(1, 1, 3'b000, CD, 3'b000, 3'b000, 0, 3'b111);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            color = vecs[i].color;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {3'b0, grant, done, busy, r, g, b},
                {3'b0, vecs[i].g, vecs[i].d, vecs[i].b, vecs[i].rgb});
        end

        // async reset during requester 1's hold at count 2
        req = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_grant", {13'b0, grant}, 16'h0002);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_now", {7'b0, grant, done, busy, r, g, b}, {7'b0, 3'b000, 3'b000, 1'b0, 3'b111});
        @(posedge clk);
        #1;
        chk("async_rst_nodone", {7'b0, grant, done, busy, r, g, b}, {7'b0, 3'b000, 3'b000, 1'b0, 3'b111});
        rst_n = 1'b1;
        req = 3'b111;
        @(posedge clk);
        #1;
        chk("post_rst_grant0", {13'b0, grant}, 16'h0001);

        // zero-gap instance: back-to-back owners separated by one IDLE cycle
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 3'b011;
        @(posedge clk);
        #1;
        chk("g0_first", {7'b0, grant0, done0, busy0, r0, g0, b0}, {7'b0, 3'b001, 3'b000, 1'b1, 3'b011});
        repeat (4) @(posedge clk);
        #1;
        chk("g0_idle", {7'b0, grant0, done0, busy0, r0, g0, b0}, {7'b0, 3'b000, 3'b001, 1'b0, 3'b111});
        @(posedge clk);
        #1;
        chk("g0_second", {7'b0, grant0, done0, busy0, r0, g0, b0}, {7'b0, 3'b010, 3'b000, 1'b1, 3'b001});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
